// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file and its
// user-capture handshake.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_IN_REG = 30;
  localparam int DEF_USER_W = 6;
  localparam int WR_COUNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

endpackage

// File: rtl/register_file_param_user_capture.sv
// Four-phase handshake: one capture strobe per user_valid assertion, with
// user_ack held until user_valid drops.
module user_capture
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic user_valid,
  output logic capture,
  output logic user_ack
);

  cap_state_t state, state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: if (user_valid) begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (!user_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign user_ack = (state == HOLD);

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: two combinational read ports with optional
// write bypass, user capture into IN_REG, registered display and write counter.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int HARD_ZERO = 1,
  parameter int IN_REG    = DEF_IN_REG,
  parameter int USER_W    = DEF_USER_W,
  parameter int BYPASS    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     readRegister1,
  input  logic [ADDR_W-1:0]     readRegister2,
  output logic [DATA_W-1:0]     readData1,
  output logic [DATA_W-1:0]     readData2,
  input  logic                  RegWrite,
  input  logic [ADDR_W-1:0]     writeRegister,
  input  logic [DATA_W-1:0]     writeData,
  input  logic [USER_W-1:0]     user_number,
  input  logic                  user_valid,
  output logic                  user_ack,
  input  logic [ADDR_W-1:0]     disp_sel,
  output logic [DATA_W-1:0]     toDisplay,
  output logic [WR_COUNT_W-1:0] wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IN_ADDR = ADDR_W'(IN_REG);

  logic [DATA_W-1:0]     regs [DEPTH];
  logic [DATA_W-1:0]     cap_data;
  logic                  capture;
  logic                  sw_we;
  logic [DATA_W-1:0]     disp_p1;
  logic [WR_COUNT_W-1:0] count_p1;

  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Value a read of address a sees this cycle, including same-cycle writes.
  function automatic logic [DATA_W-1:0] lookup(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              cap,
    input logic [DATA_W-1:0] cap_d,
    input logic              sw,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (HARD_ZERO != 0 && a == '0)            return '0;
    if (BYPASS != 0 && cap && a == IN_ADDR)   return cap_d;
    if (BYPASS != 0 && sw && a == wa)         return wd;
    return stored;
  endfunction

  user_capture u_capture (
    .clock      (clock),
    .reset_n    (reset_n),
    .user_valid (user_valid),
    .capture    (capture),
    .user_ack   (user_ack)
  );

  assign cap_data = DATA_W'(user_number);

  // A capture owns IN_REG on its edge; writes elsewhere still go through.
  assign sw_we = RegWrite
               && !(HARD_ZERO != 0 && writeRegister == '0)
               && !(capture && writeRegister == IN_ADDR);

  always_comb begin
    readData1 = lookup(readRegister1, regs[readRegister1], capture, cap_data,
                       sw_we, writeRegister, writeData);
    readData2 = lookup(readRegister2, regs[readRegister2], capture, cap_data,
                       sw_we, writeRegister, writeData);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{default: '0};
    end else begin
      if (sw_we)   regs[writeRegister] <= writeData;
      if (capture) regs[IN_ADDR]       <= cap_data;
    end
  end

  // Stage p1: display snapshot and write counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_p1  <= '0;
      count_p1 <= '0;
    end else begin
      disp_p1 <= lookup(disp_sel, regs[disp_sel], capture, cap_data,
                        sw_we, writeRegister, writeData);
      if (sw_we || capture) count_p1 <= sat_inc(count_p1);
    end
  end

  assign toDisplay = disp_p1;
  assign wr_count  = count_p1;

endmodule
